requant_sched: RTL and testbench
================================

# requant_sched

Shared requantization scheduler for the accelerator's output path. Two accumulator-drain requesters (e.g. two PE-array columns) compete for one requant datapath. The block arbitrates round-robin and looks up per-channel multiplier/shift/offset from a small writable parameter table. It sequences the two requant steps (high-multiply, then shift-plus-offset), clamps to int8 and returns the result with the winning requester's ID. Configuration is written through a narrow register port driven by the CFU command decoder.

## Interface
Parameters:
- NUM_CH, 16, depth of per-channel parameter table
- CH_W, 4, channel index width (log2 NUM_CH)
- ACT_MIN, -128, lower clamp bound (signed 32-bit)
- ACT_MAX, 127, upper clamp bound (signed 32-bit)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- cfg_wr  in  1  parameter-table write strobe
- cfg_sel  in  2  0 = multiplier, 1 = shift, 2 = offset, 3 = ignored (no write)
- cfg_addr  in  CH_W  channel to write
- cfg_data  in  32  write data; shift uses cfg_data[4:0]
- req0_valid / req1_valid  in  1  requester has an accumulator
- req0_ready / req1_ready  out  1  accept, combinational
- req0_acc / req1_acc  in  32  signed int32 accumulator
- req0_ch / req1_ch  in  CH_W  channel index
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  8  signed int8 result
- out_src  out  1  requester ID of result
- busy  out  1  high whenever state != IDLE

## Operation
- FSM states: IDLE, MUL, SHIFT, DONE. One item is in flight at a time.
- Grant logic (combinational, IDLE only):
  - only reqN_valid high: grant N
  - both high: grant the one that is not last_grant
  - reqN_ready = (state==IDLE) && grant==N; at most one ready is ever high.
- Accept (IDLE and reqN_valid && reqN_ready):
  - capture acc, src=N, and mult/shift/offset of table[ch]
  - last_grant <= N
  - go to MUL
- MUL: prod = signed(acc) * signed(mult), 64-bit. hi = prod >>> 31, truncated to low 32 bits. Arithmetic shift, no rounding nudge, no saturation. Go to SHIFT.
- SHIFT: r = (hi >>> shift) + offset, 32-bit wrap-around add. Clamp r to [ACT_MIN, ACT_MAX]. out_data <= r[7:0], out_valid <= 1. Go to DONE.
- DONE: hold out_data/out_src/out_valid stable. On out_valid && out_ready: out_valid <= 0, go to IDLE.
- Config writes:
  - accepted in any state and take effect next cycle
  - captured params of an in-flight item are unaffected
  - cfg_wr in the same cycle as an accept on the same channel: the accepted item uses the old value (read-before-write)
- cfg_addr >= NUM_CH: write ignored. Out-of-range reqN_ch: params read as 0.

## Timing
- Reset values:
  - all outputs 0: out_valid, out_data, out_src, busy; req*_ready follow the FSM, so req0_ready = req0_valid after reset
  - state IDLE, last_grant = 1 (req0 wins the first tie)
  - table entries all 0
- Latency: accept edge E0 → MUL at E1 → out_valid high after E2 (2 cycles accept-to-valid).
- Throughput: with out_ready held high, one result per 4 cycles (IDLE, MUL, SHIFT, DONE).
- Reset mid-operation (any state): item discarded, FSM to IDLE, out_valid 0 next cycle, table cleared.
- req*_valid may drop without a handshake; no accept occurs unless valid && ready are both high at the edge.

## Test plan
- Basic requant:
  - setup: ch3 mult=0x40000000, shift=2, offset=-5
  - stimulus: req0 acc=1000, ch=3
  - response: out_valid 2 cycles after accept, out_data=120 (0x78), out_src=0
- Negative and clamp-low:
  - setup: ch0 mult=0x40000000, shift=0, offset=0
  - stimulus: acc=-1001
  - response: hi=-501, out_data=-128 (0x80)
- Clamp-high:
  - setup: ch1 mult=0x7FFFFFFF, shift=0, offset=0
  - stimulus: acc=1000
  - response: hi=999, out_data=127
- Arbitration:
  - stimulus: both requesters valid continuously, out_ready=1
  - response: grant order 0,1,0,1; never both ready; exactly one result per 4 cycles
- Backpressure:
  - stimulus: hold out_ready=0 for 5 cycles in DONE, with req1_valid high throughout
  - response: out_data/out_src stable; req1_ready=0 until the DONE handshake, then IDLE and accept next cycle
- Reset and config race:
  - stimulus: assert reset during SHIFT
  - response: out_valid stays 0; busy drops; table reads 0
  - stimulus: cfg_wr to ch2 offset in the same cycle as a ch2 accept
  - response: the item uses the old offset; the next ch2 item uses the new one

Source files
------------

// File: rtl/requant_sched.sv
// -----------------------------------------------------------------------------
// requant_sched
//
// Shared requantization scheduler. Two accumulator-drain requesters compete
// round-robin for one requant datapath. The winning item captures its
// per-channel multiplier/shift/offset from a small writable table. It then
// steps through a high-multiply (MUL) and a shift-plus-offset with int8
// clamp (SHIFT). The result is held in DONE until the consumer takes it.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   cfg_wr/sel/addr/data  parameter-table write port
//                         sel: 0 mult, 1 shift, 2 offset, 3 no write
//   reqN_valid/ready      requester handshake; ready is combinational
//   reqN_acc, reqN_ch     signed int32 accumulator and its channel index
//   out_valid/ready       result handshake
//   out_data, out_src     signed int8 result and the winning requester ID
//   busy                  high whenever the scheduler is not IDLE
// -----------------------------------------------------------------------------
module requant_sched #(
    parameter int NUM_CH  = 16,
    parameter int CH_W    = 4,
    parameter int ACT_MIN = -128,
    parameter int ACT_MAX = 127
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_wr,
    input  logic [1:0]      cfg_sel,
    input  logic [CH_W-1:0] cfg_addr,
    input  logic [31:0]     cfg_data,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [31:0]     req0_acc,
    input  logic [CH_W-1:0] req0_ch,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [31:0]     req1_acc,
    input  logic [CH_W-1:0] req1_ch,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_data,
    output logic            out_src,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, MUL, SHIFT, DONE} state_t;

    state_t state_reg, state_next;

    // Parameter table. Kept in registers because reset must clear it and an
    // accept must see the current contents in the same cycle.
    logic [31:0] mult_tbl  [NUM_CH];
    logic [4:0]  shift_tbl [NUM_CH];
    logic [31:0] off_tbl   [NUM_CH];

    logic [NUM_CH-1:0] wr_mult, wr_shift, wr_off;

    // Per-entry write decode. Addresses beyond the table match no entry, so
    // such writes fall away naturally.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_wr_dec
            assign wr_mult[gi]  = cfg_wr && (cfg_sel == 2'd0) && (cfg_addr == CH_W'(gi));
            assign wr_shift[gi] = cfg_wr && (cfg_sel == 2'd1) && (cfg_addr == CH_W'(gi));
            assign wr_off[gi]   = cfg_wr && (cfg_sel == 2'd2) && (cfg_addr == CH_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mult_tbl[i]  <= '0;
                shift_tbl[i] <= '0;
                off_tbl[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_mult[i])  mult_tbl[i]  <= cfg_data;
                if (wr_shift[i]) shift_tbl[i] <= cfg_data[4:0];
                if (wr_off[i])   off_tbl[i]   <= cfg_data;
            end
        end
    end

    // Captured item and datapath registers
    logic        [31:0] acc_reg;
    logic signed [31:0] mult_reg;
    logic        [4:0]  shift_reg;
    logic signed [31:0] off_reg;
    logic signed [31:0] hi_reg;
    logic               src_reg;
    logic               last_grant_reg;
    logic               out_valid_reg;
    logic        [7:0]  out_data_reg;
    logic               out_src_reg;

    // Grant / handshake
    logic            grant1;
    logic            accept;
    logic [CH_W-1:0] sel_ch;
    logic            sel_in_range;
    logic [31:0]     sel_mult, sel_off;
    logic [4:0]      sel_shift;

    always_comb begin
        state_next = state_reg;
        grant1     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_reg)
            IDLE: begin
                // On a tie the requester that did not win last time goes
                grant1     = req1_valid && (!req0_valid || !last_grant_reg);
                req1_ready = grant1;
                req0_ready = req0_valid && !grant1;
                if (req0_valid || req1_valid) state_next = MUL;
            end
            MUL:   state_next = SHIFT;
            SHIFT: state_next = DONE;
            DONE:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign accept = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    // Table read for the granted channel; out-of-range channels read as zero
    assign sel_ch       = grant1 ? req1_ch : req0_ch;
    assign sel_in_range = (32'(sel_ch) < NUM_CH);
    assign sel_mult     = sel_in_range ? mult_tbl[sel_ch]  : '0;
    assign sel_shift    = sel_in_range ? shift_tbl[sel_ch] : '0;
    assign sel_off      = sel_in_range ? off_tbl[sel_ch]   : '0;

    // High-multiply: the low 64 bits of an unsigned product of the
    // sign-extended operands equal the signed 64-bit product.
    logic [63:0] prod;
    assign prod = {{32{acc_reg[31]}}, acc_reg} * {{32{mult_reg[31]}}, mult_reg};

    // Shift, offset (wrapping add) and clamp
    logic signed [31:0] shifted, summed, clamped;
    localparam logic signed [31:0] CLAMP_LO = ACT_MIN;
    localparam logic signed [31:0] CLAMP_HI = ACT_MAX;

    always_comb begin
        shifted = hi_reg >>> shift_reg;
        summed  = shifted + off_reg;
        clamped = summed;
        if (summed < CLAMP_LO)      clamped = CLAMP_LO;
        else if (summed > CLAMP_HI) clamped = CLAMP_HI;
    end

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg        <= '0;
            mult_reg       <= '0;
            shift_reg      <= '0;
            off_reg        <= '0;
            hi_reg         <= '0;
            src_reg        <= 1'b0;
            last_grant_reg <= 1'b1;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_src_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        acc_reg        <= grant1 ? req1_acc : req0_acc;
                        src_reg        <= grant1;
                        mult_reg       <= sel_mult;
                        shift_reg      <= sel_shift;
                        off_reg        <= sel_off;
                        last_grant_reg <= grant1;
                    end
                end
                MUL: hi_reg <= prod[62:31];
                SHIFT: begin
                    out_data_reg  <= clamped[7:0];
                    out_src_reg   <= src_reg;
                    out_valid_reg <= 1'b1;
                end
                DONE: begin
                    if (out_ready) out_valid_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_src   = out_src_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_requant_sched.sv
// -----------------------------------------------------------------------------
// tb_requant_sched
//
// Scoreboard bench for requant_sched. The driver drives inputs #1 after each
// rising edge and evaluates at the falling edge which requester should be
// accepted, from its own round-robin and parameter-table model. It pushes the
// expected result into a queue. A separate monitor pops and compares whenever
// the DUT hands over a result.
// -----------------------------------------------------------------------------
module tb_requant_sched;

    localparam int NUM_CH = 16;
    localparam int CH_W   = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            cfg_wr = 1'b0;
    logic [1:0]      cfg_sel = '0;
    logic [CH_W-1:0] cfg_addr = '0;
    logic [31:0]     cfg_data = '0;
    logic            req0_valid = 1'b0, req1_valid = 1'b0;
    logic            req0_ready, req1_ready;
    logic [31:0]     req0_acc = '0, req1_acc = '0;
    logic [CH_W-1:0] req0_ch = '0, req1_ch = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [7:0]      out_data;
    logic            out_src;
    logic            busy;

    requant_sched #(.NUM_CH(NUM_CH), .CH_W(CH_W), .ACT_MIN(-128), .ACT_MAX(127)) dut (
        .clk(clk), .reset(reset),
        .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_acc(req0_acc), .req0_ch(req0_ch),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_acc(req1_acc), .req1_ch(req1_ch),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       src;
        int         stamp;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;
    int pend = 0;
    int last_hs_cyc = -10;
    int accepted = -1;
    int m_mult[NUM_CH];
    int m_shift[NUM_CH];
    int m_off[NUM_CH];
    int m_last = 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: hi = (acc*mult) >> 31 arithmetic, then >> shift, + offset,
    // clamp to int8.
    function automatic logic [7:0] ref_rq(input int acc, input int mult, input int sh, input int off);
        longint prod;
        int hi;
        int r;
        prod = longint'(acc) * longint'(mult);
        hi   = int'(prod >>> 31);
        r    = (hi >>> sh) + off;
        if (r < -128)     r = -128;
        else if (r > 127) r = 127;
        return r[7:0];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NUM_CH; i++) begin
            m_mult[i] = 0; m_shift[i] = 0; m_off[i] = 0;
        end
        m_last = 1;
        q.delete();
        pend = 0;
    endtask

    // One clock cycle: evaluate expected readiness and acceptance before the
    // edge, then advance to just after the edge.
    task automatic cycle();
        bit idle_exp, w0, w1;
        int a, c, s;
        @(negedge clk);
        #1;
        accepted = -1;
        if (!reset) begin
            idle_exp = (pend == 0) && (last_hs_cyc != cyc);
            w1 = req1_valid && (!req0_valid || m_last == 0);
            w0 = req0_valid && !w1;
            chk("req0_ready", req0_ready, idle_exp && w0);
            chk("req1_ready", req1_ready, idle_exp && w1);
            if (idle_exp && (w0 || w1)) begin
                s = w1 ? 1 : 0;
                a = s ? req1_acc : req0_acc;
                c = s ? int'(req1_ch) : int'(req0_ch);
                q.push_back('{ref_rq(a, m_mult[c], m_shift[c], m_off[c]), s[0], cyc + 1});
                m_last = s;
                pend++;
                accepted = s;
            end
            // Table write lands at the edge, after any accept has read it
            if (cfg_wr && cfg_sel != 2'd3 && int'(cfg_addr) < NUM_CH) begin
                case (cfg_sel)
                    2'd0: m_mult[cfg_addr]  = cfg_data;
                    2'd1: m_shift[cfg_addr] = int'(cfg_data[4:0]);
                    default: m_off[cfg_addr] = cfg_data;
                endcase
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input int addr, input int data);
        cfg_wr = 1'b1; cfg_sel = sel; cfg_addr = addr[CH_W-1:0]; cfg_data = data;
        cycle();
        cfg_wr = 1'b0;
    endtask

    task automatic send(input int src, input int acc, input int ch);
        int n;
        n = 0;
        if (src == 0) begin req0_valid = 1'b1; req0_acc = acc; req0_ch = ch[CH_W-1:0]; end
        else          begin req1_valid = 1'b1; req1_acc = acc; req1_ch = ch[CH_W-1:0]; end
        do begin
            cycle();
            n++;
        end while (accepted != src && n < 20);
        if (accepted != src) begin
            errors++; checks++;
            $display("FAIL send_timeout: requester %0d not accepted within 20 cycles", src);
        end
        if (src == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (pend != 0 && n < 50) begin
            cycle();
            n++;
        end
        if (pend != 0) begin
            errors++; checks++;
            $display("FAIL drain_timeout: %0d results still pending", pend);
        end
    endtask

    // Monitor: compare every handed-over result against the scoreboard and
    // check that a stalled result holds still.
    initial begin : monitor
        bit         prev_valid;
        bit         held;
        logic [7:0] hd;
        logic       hs;
        prev_valid = 0; held = 0; hd = '0; hs = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_valid = 0; held = 0;
            end else begin
                if (out_valid) begin
                    if (q.size() == 0) begin
                        errors++; checks++;
                        $display("FAIL unexpected_out: data=%0d src=%0d with empty scoreboard", out_data, out_src);
                    end else begin
                        if (!prev_valid) chk("latency", cyc - q[0].stamp, 2);
                        if (held) begin
                            chk("hold_data", out_data, hd);
                            chk("hold_src", out_src, hs);
                        end
                        if (out_ready) begin
                            chk("out_data", out_data, q[0].data);
                            chk("out_src", out_src, q[0].src);
                            $display("txn cyc=%0d src=%0d data=%0d exp_src=%0d exp_data=%0d",
                                     cyc, out_src, $signed(out_data), q[0].src, $signed(q[0].data));
                            void'(q.pop_front());
                            pend--;
                            last_hs_cyc = cyc;
                            held = 0;
                        end else begin
                            held = 1; hd = out_data; hs = out_src;
                        end
                    end
                end else if (held) begin
                    errors++; checks++;
                    $display("FAIL valid_drop: out_valid fell without a handshake");
                    held = 0;
                end
                prev_valid = out_valid;
            end
        end
    end

    initial begin : driver
        model_clear();
        // Reset state
        reset = 1'b1; req0_valid = 1'b1;
        cycle(); cycle();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        cycle();                       // req0 accepted straight out of reset
        chk("first_accept", accepted, 0);
        req0_valid = 1'b0;
        drain();

        // Basic requant on ch3: expected 120 from src 0
        cfg_write(2'd0, 3, 32'h4000_0000);
        cfg_write(2'd1, 3, 2);
        cfg_write(2'd2, 3, -5);
        send(0, 1000, 3);
        drain();
        // Clamp-low on ch0 and clamp-high on ch1
        cfg_write(2'd0, 0, 32'h4000_0000);
        send(1, -1001, 0);
        drain();
        cfg_write(2'd0, 1, 32'h7FFF_FFFF);
        send(0, 1000, 1);
        drain();

        // Arbitration: both valid continuously, results every 4 cycles
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_acc = 700; req1_acc = -300; req0_ch = 3; req1_ch = 1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) cycle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        // Backpressure: req0 item stalls 5 cycles in DONE with req1 waiting
        out_ready = 1'b0;
        send(0, 4000, 3);
        req1_valid = 1'b1; req1_acc = 2000; req1_ch = 3;
        for (int i = 0; i < 7; i++) cycle();
        chk("bp_busy", busy, 1);
        out_ready = 1'b1;
        cycle();                       // handshake edge
        cycle();                       // IDLE: req1 accepted here
        chk("bp_req1_accept", accepted, 1);
        req1_valid = 1'b0;
        drain();

        // Reset during SHIFT discards the item and clears the table
        cfg_write(2'd0, 5, 32'h4000_0000);
        cfg_write(2'd2, 5, 50);
        req0_valid = 1'b1; req0_acc = 800; req0_ch = 5;
        cycle();                       // accept edge
        req0_valid = 1'b0;
        cycle();                       // now in SHIFT
        chk("shift_busy", busy, 1);
        reset = 1'b1;
        cycle();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        model_clear();
        reset = 1'b0;
        cycle();
        chk("postrst_out_valid", out_valid, 0);
        send(0, 800, 5);               // table cleared: expected 0
        drain();

        // Config race on ch2: same-cycle write must not affect the item
        cfg_write(2'd0, 2, 32'h4000_0000);
        cfg_write(2'd2, 2, 10);
        req1_valid = 1'b1; req1_acc = 100; req1_ch = 2;
        cfg_wr = 1'b1; cfg_sel = 2'd2; cfg_addr = 2; cfg_data = -20;
        cycle();
        chk("race_accept", accepted, 1);
        cfg_wr = 1'b0; req1_valid = 1'b0;
        drain();
        send(1, 100, 2);
        drain();

        // Randomized traffic with config writes in flight
        for (int i = 0; i < 400; i++) begin
            req0_valid = ($urandom_range(0, 9) < 6);
            req1_valid = ($urandom_range(0, 9) < 6);
            req0_acc   = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($signed(12'($urandom())));
            req1_acc   = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($signed(12'($urandom())));
            req0_ch    = CH_W'($urandom_range(0, NUM_CH - 1));
            req1_ch    = CH_W'($urandom_range(0, NUM_CH - 1));
            out_ready  = ($urandom_range(0, 9) < 7);
            cfg_wr     = ($urandom_range(0, 4) == 0);
            cfg_sel    = 2'($urandom_range(0, 3));
            cfg_addr   = CH_W'($urandom_range(0, NUM_CH - 1));
            case (cfg_sel)
                2'd0:    cfg_data = $urandom() >> $urandom_range(0, 20);
                2'd1:    cfg_data = $urandom();
                default: cfg_data = 32'($signed(9'($urandom())));
            endcase
            cycle();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; cfg_wr = 1'b0;
        drain();
        chk("queue_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
